// File: rtl/branch_thread_scheduler.sv
// Branch thread scheduler: holds one unresolved branch per hardware thread,
// arbitrates them round-robin onto the shared branch unit and tracks each
// branch through resolution, flush and mispredict redirect.
module branch_thread_scheduler #(
   parameter int unsigned NrThreads = 2,
   parameter int unsigned VLEN      = 39,
   parameter int unsigned TidW      = $clog2(NrThreads)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NrThreads-1:0]      req_valid_i,
   input  logic [NrThreads*VLEN-1:0] req_pc_i,
   output logic [NrThreads-1:0]      req_ready_o,
   input  logic [NrThreads-1:0]      flush_i,
   output logic                      bu_valid_o,
   output logic [VLEN-1:0]           bu_pc_o,
   output logic [TidW-1:0]           bu_thread_id_o,
   input  logic                      res_valid_i,
   input  logic                      res_mispredict_i,
   input  logic [TidW-1:0]           res_thread_id_i,
   input  logic [NrThreads-1:0]      redirect_ack_i,
   output logic [NrThreads-1:0]      blocked_o
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_PEND    = 3'd1;
   localparam logic [2:0] ST_FLIGHT  = 3'd2;
   localparam logic [2:0] ST_DRAIN   = 3'd3;
   localparam logic [2:0] ST_BLOCKED = 3'd4;

   // One extra bit so rr_ptr + offset never overflows before the wrap.
   localparam int unsigned SumW = TidW + 1;

   logic [2:0]           state_q [NrThreads];
   logic [2:0]           state_d [NrThreads];
   logic [VLEN-1:0]      pc_q    [NrThreads];
   logic [VLEN-1:0]      pc_d    [NrThreads];
   logic [TidW-1:0]      rr_ptr_q, rr_ptr_d;
   logic                 bu_valid_q, bu_valid_d;
   logic [VLEN-1:0]      bu_pc_q, bu_pc_d;
   logic [TidW-1:0]      bu_tid_q, bu_tid_d;

   logic [NrThreads-1:0] cand_c;
   logic [NrThreads-1:0] grant_c;
   logic [NrThreads-1:0] res_hit_c;
   logic [NrThreads-1:0] res_awaited_c;
   logic                 grant_found_c;
   logic [TidW-1:0]      grant_id_c;
   logic [SumW-1:0]      idx_c;

   // Per-thread decode of state: acceptance, blocked status, resolution match.
   always_comb begin
      req_ready_o   = '0;
      blocked_o     = '0;
      cand_c        = '0;
      res_hit_c     = '0;
      res_awaited_c = '0;
      for (int t = 0; t < NrThreads; t++) begin
         req_ready_o[t]   = (state_q[t] == ST_IDLE) && !flush_i[t] && !rst_i;
         blocked_o[t]     = (state_q[t] == ST_BLOCKED);
         cand_c[t]        = (state_q[t] == ST_PEND) && !flush_i[t];
         res_hit_c[t]     = res_valid_i && (res_thread_id_i == TidW'(t));
         res_awaited_c[t] = (state_q[t] == ST_FLIGHT) || (state_q[t] == ST_DRAIN);
      end
   end

   // Round-robin search over pending, non-flushed threads starting at rr_ptr.
   always_comb begin
      grant_c       = '0;
      grant_found_c = 1'b0;
      grant_id_c    = '0;
      idx_c         = '0;
      for (int unsigned k = 0; k < NrThreads; k++) begin
         idx_c = SumW'(rr_ptr_q) + SumW'(k);
         if (idx_c >= SumW'(NrThreads)) begin
            idx_c = idx_c - SumW'(NrThreads);
         end
         if (!grant_found_c && cand_c[idx_c[TidW-1:0]]) begin
            grant_found_c = 1'b1;
            grant_id_c    = idx_c[TidW-1:0];
         end
      end
      if (grant_found_c) begin
         grant_c[grant_id_c] = 1'b1;
      end
   end

   // Issue register and pointer update; valid is a one-cycle pulse per grant.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      bu_valid_d = grant_found_c;
      bu_pc_d    = bu_pc_q;
      bu_tid_d   = bu_tid_q;
      if (grant_found_c) begin
         bu_pc_d  = pc_q[grant_id_c];
         bu_tid_d = grant_id_c;
         rr_ptr_d = (grant_id_c == TidW'(NrThreads - 1)) ? '0 : grant_id_c + TidW'(1);
      end
   end

   // Per-thread next state; flush beats resolution, resolution beats ack.
   always_comb begin
      for (int t = 0; t < NrThreads; t++) begin
         state_d[t] = state_q[t];
         pc_d[t]    = pc_q[t];
         case (state_q[t])
            ST_IDLE: begin
               if (req_valid_i[t] && req_ready_o[t]) begin
                  state_d[t] = ST_PEND;
                  pc_d[t]    = req_pc_i[t*VLEN +: VLEN];
               end
            end
            ST_PEND: begin
               if (flush_i[t]) begin
                  state_d[t] = ST_IDLE;
               end else if (grant_c[t]) begin
                  state_d[t] = ST_FLIGHT;
               end
            end
            ST_FLIGHT: begin
               if (flush_i[t]) begin
                  state_d[t] = ST_DRAIN;
               end else if (res_hit_c[t]) begin
                  state_d[t] = res_mispredict_i ? ST_BLOCKED : ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (!flush_i[t] && res_hit_c[t]) begin
                  state_d[t] = ST_IDLE;
               end
            end
            ST_BLOCKED: begin
               if (flush_i[t] || redirect_ack_i[t]) begin
                  state_d[t] = ST_IDLE;
               end
            end
            default: state_d[t] = ST_IDLE;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int t = 0; t < NrThreads; t++) begin
            state_q[t] <= ST_IDLE;
            pc_q[t]    <= '0;
         end
         rr_ptr_q   <= '0;
         bu_valid_q <= 1'b0;
         bu_pc_q    <= '0;
         bu_tid_q   <= '0;
      end else begin
         for (int t = 0; t < NrThreads; t++) begin
            state_q[t] <= state_d[t];
            pc_q[t]    <= pc_d[t];
         end
         rr_ptr_q   <= rr_ptr_d;
         bu_valid_q <= bu_valid_d;
         bu_pc_q    <= bu_pc_d;
         bu_tid_q   <= bu_tid_d;
      end
   end

   assign bu_valid_o     = bu_valid_q;
   assign bu_pc_o        = bu_pc_q;
   assign bu_thread_id_o = bu_tid_q;

   // At most one thread granted per cycle.
   a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(grant_c));

   // A thread can never be issued on two consecutive cycles.
   a_no_back_to_back: assert property (@(posedge clk_i) disable iff (rst_i)
      (bu_valid_q && $past(bu_valid_q)) |-> (bu_tid_q != $past(bu_tid_q)));

   // Resolutions for threads without an outstanding branch are dropped.
   a_res_expected: assert property (@(posedge clk_i) disable iff (rst_i)
      res_valid_i |-> res_awaited_c[res_thread_id_i])
      else $warning("branch_thread_scheduler: ignored resolution for thread %0d", res_thread_id_i);

endmodule

// File: tb/tb_branch_thread_scheduler.sv
// Testbench for branch_thread_scheduler: directed vector table, hand-written
// corner sequences, then random traffic against a behavioural model.
module tb_branch_thread_scheduler;

   localparam int NT = 2;
   localparam int VL = 39;

   logic            clk = 1'b0;
   logic            rst;
   logic [NT-1:0]   req_valid;
   logic [VL-1:0]   pc0, pc1;
   logic [NT-1:0]   req_ready;
   logic [NT-1:0]   flush;
   logic            bu_valid;
   logic [VL-1:0]   bu_pc;
   logic            bu_tid;
   logic            res_valid, res_mis, res_tid;
   logic [NT-1:0]   ack;
   logic [NT-1:0]   blocked;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   branch_thread_scheduler #(.NrThreads(NT), .VLEN(VL)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req_valid_i      (req_valid),
      .req_pc_i         ({pc1, pc0}),
      .req_ready_o      (req_ready),
      .flush_i          (flush),
      .bu_valid_o       (bu_valid),
      .bu_pc_o          (bu_pc),
      .bu_thread_id_o   (bu_tid),
      .res_valid_i      (res_valid),
      .res_mispredict_i (res_mis),
      .res_thread_id_i  (res_tid),
      .redirect_ack_i   (ack),
      .blocked_o        (blocked)
   );

   typedef struct {
      logic          rst;
      logic [1:0]    rv;
      logic [VL-1:0] p0;
      logic [VL-1:0] p1;
      logic [1:0]    fl;
      logic          resv;
      logic          resm;
      logic          rest;
      logic [1:0]    ack;
      logic [1:0]    e_rdy;
      logic [1:0]    e_blk;
      logic          e_bv;
      logic [VL-1:0] e_pc;
      logic          e_tid;
   } vec_t;

   vec_t vecs[25];

   // Behavioural model: what each thread is holding, plus issue outputs.
   bit            m_hold   [NT];
   bit            m_issued [NT];
   bit            m_killed [NT];
   bit            m_blk    [NT];
   logic [VL-1:0] m_pc     [NT];
   int            m_rr;
   bit            m_bv;
   logic [VL-1:0] m_bpc;
   bit            m_btid;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] rv, input logic [VL-1:0] p0,
                        input logic [VL-1:0] p1, input logic [1:0] fl, input logic rsv,
                        input logic rsm, input logic rst_id, input logic [1:0] ak);
      rst = r; req_valid = rv; pc0 = p0; pc1 = p1; flush = fl;
      res_valid = rsv; res_mis = rsm; res_tid = rst_id; ack = ak;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit m_idle(input int t);
      return !(m_hold[t] || m_issued[t] || m_killed[t] || m_blk[t]);
   endfunction

   // Advance the model by one clock given this cycle's inputs.
   task automatic model_step(input logic r, input logic [1:0] rv, input logic [VL-1:0] p0,
                             input logic [VL-1:0] p1, input logic [1:0] fl, input logic rsv,
                             input logic rsm, input logic rst_id, input logic [1:0] ak);
      logic [VL-1:0] pcs [NT];
      int best, bestd, d;
      bit res_t;
      pcs[0] = p0; pcs[1] = p1;
      if (r) begin
         for (int t = 0; t < NT; t++) begin
            m_hold[t] = 0; m_issued[t] = 0; m_killed[t] = 0; m_blk[t] = 0; m_pc[t] = '0;
         end
         m_rr = 0; m_bv = 0; m_bpc = '0; m_btid = 0;
         return;
      end
      best = -1; bestd = NT;
      for (int t = 0; t < NT; t++) begin
         if (m_hold[t] && !fl[t]) begin
            d = (t - m_rr + NT) % NT;
            if (d < bestd) begin bestd = d; best = t; end
         end
      end
      m_bv = (best >= 0);
      if (best >= 0) begin
         m_bpc  = m_pc[best];
         m_btid = best[0];
         m_rr   = (best + 1) % NT;
      end
      for (int t = 0; t < NT; t++) begin
         res_t = rsv && (int'(rst_id) == t);
         if (m_idle(t)) begin
            if (rv[t] && !fl[t]) begin m_hold[t] = 1; m_pc[t] = pcs[t]; end
         end else if (m_hold[t]) begin
            if (fl[t]) m_hold[t] = 0;
            else if (best == t) begin m_hold[t] = 0; m_issued[t] = 1; end
         end else if (m_issued[t]) begin
            if (fl[t]) begin m_issued[t] = 0; m_killed[t] = 1; end
            else if (res_t) begin m_issued[t] = 0; m_blk[t] = rsm; end
         end else if (m_killed[t]) begin
            if (res_t && !fl[t]) m_killed[t] = 0;
         end else if (m_blk[t]) begin
            if (fl[t] || ak[t]) m_blk[t] = 0;
         end
      end
   endtask

   initial begin
      logic [1:0]    rv, fl, ak, erdy, eblk;
      logic [VL-1:0] rp0, rp1;
      logic          rr_, rsv, rsm, rtid;
      int            t;

      //            rst  rv     p0        p1        fl     rv m  t  ack    rdy    blk    bv  pc        tid
      vecs[0]  = '{1'b1, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 39'h0,    0};
      vecs[1]  = '{1'b0, 2'b01, 39'h1000, 39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 39'h0,    0};
      vecs[2]  = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 39'h0,    0};
      vecs[3]  = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 1, 0, 0, 2'b00, 2'b10, 2'b00, 1, 39'h1000, 0};
      vecs[4]  = '{1'b0, 2'b10, 39'h0,    39'h2000, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 39'h1000, 0};
      vecs[5]  = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 39'h1000, 0};
      vecs[6]  = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 1, 1, 1, 2'b00, 2'b01, 2'b00, 1, 39'h2000, 1};
      vecs[7]  = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 39'h2000, 1};
      vecs[8]  = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b01, 2'b01, 2'b10, 0, 39'h2000, 1};
      vecs[9]  = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b10, 2'b01, 2'b10, 0, 39'h2000, 1};
      vecs[10] = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 39'h2000, 1};
      vecs[11] = '{1'b0, 2'b01, 39'h3000, 39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 39'h2000, 1};
      vecs[12] = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 39'h2000, 1};
      vecs[13] = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b01, 0, 0, 0, 2'b00, 2'b10, 2'b00, 1, 39'h3000, 0};
      vecs[14] = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 39'h3000, 0};
      vecs[15] = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 39'h3000, 0};
      vecs[16] = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 39'h3000, 0};
      vecs[17] = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 39'h3000, 0};
      vecs[18] = '{1'b0, 2'b11, 39'h4000, 39'h5000, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 39'h3000, 0};
      vecs[19] = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 39'h3000, 0};
      vecs[20] = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 1, 0, 1, 2'b00, 2'b00, 2'b00, 1, 39'h5000, 1};
      vecs[21] = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 1, 0, 0, 2'b00, 2'b10, 2'b00, 1, 39'h4000, 0};
      vecs[22] = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 39'h4000, 0};
      vecs[23] = '{1'b0, 2'b01, 39'h0,    39'h0,    2'b01, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 39'h4000, 0};
      vecs[24] = '{1'b0, 2'b00, 39'h0,    39'h0,    2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 39'h4000, 0};

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Directed table: basic flow, mispredict/ack, flush in flight, round-robin.
      for (int i = 0; i < 25; i++) begin
         drive(vecs[i].rst, vecs[i].rv, vecs[i].p0, vecs[i].p1, vecs[i].fl,
               vecs[i].resv, vecs[i].resm, vecs[i].rest, vecs[i].ack);
         chk($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(vecs[i].e_rdy));
         chk($sformatf("vec%0d blocked", i),   64'(blocked),   64'(vecs[i].e_blk));
         chk($sformatf("vec%0d bu_valid", i),  64'(bu_valid),  64'(vecs[i].e_bv));
         chk($sformatf("vec%0d bu_pc", i),     64'(bu_pc),     64'(vecs[i].e_pc));
         chk($sformatf("vec%0d bu_tid", i),    64'(bu_tid),    64'(vecs[i].e_tid));
         tick();
      end

      // Flush coinciding with a mispredict resolution: drain, never block.
      drive(0, 2'b01, 39'h6000, 0, 0, 0, 0, 0, 0);
      chk("s5 ready", 64'(req_ready), 64'(2'b11)); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("s5 no issue yet", 64'(bu_valid), 64'(0)); tick();
      drive(0, 0, 0, 0, 2'b01, 1, 1, 0, 0);
      chk("s5 issue valid", 64'(bu_valid), 64'(1));
      chk("s5 issue pc", 64'(bu_pc), 64'(39'h6000)); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("s5 drain not blocked", 64'(blocked), 64'(0));
      chk("s5 drain not ready", 64'(req_ready), 64'(2'b10)); tick();
      drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
      chk("s5 drain res blocked", 64'(blocked), 64'(0)); tick();
      drive(0, 2'b10, 0, 39'h7000, 0, 0, 0, 0, 0);
      chk("s5 back to idle", 64'(req_ready), 64'(2'b11));
      chk("s5 never blocked", 64'(blocked), 64'(0)); tick();
      // Flush of the only pending thread suppresses the grant.
      drive(0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
      chk("s5 pend flush ready", 64'(req_ready), 64'(2'b01)); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("s5 no issue after flush", 64'(bu_valid), 64'(0));
      chk("s5 t1 idle again", 64'(req_ready), 64'(2'b11)); tick();

      // Reset with T1 blocked and T0 in flight, then a stale resolution.
      drive(0, 2'b10, 0, 39'h8000, 0, 0, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(0, 2'b01, 39'h9000, 0, 0, 1, 1, 1, 0);
      chk("s6 t1 issue", 64'(bu_valid), 64'(1));
      chk("s6 t1 tid", 64'(bu_tid), 64'(1));
      chk("s6 t1 pc", 64'(bu_pc), 64'(39'h8000)); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("s6 t1 blocked", 64'(blocked), 64'(2'b10)); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("s6 t0 issue", 64'(bu_valid), 64'(1));
      chk("s6 t0 pc", 64'(bu_pc), 64'(39'h9000));
      chk("s6 ready in reset", 64'(req_ready), 64'(0)); tick();
      drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
      chk("s6 post-reset ready", 64'(req_ready), 64'(2'b11));
      chk("s6 post-reset blocked", 64'(blocked), 64'(0));
      chk("s6 post-reset valid", 64'(bu_valid), 64'(0));
      chk("s6 post-reset pc", 64'(bu_pc), 64'(0)); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("s6 stale res blocked", 64'(blocked), 64'(0));
      chk("s6 stale res ready", 64'(req_ready), 64'(2'b11)); tick();

      // Random traffic against the model.
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      model_step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      for (int c = 0; c < 3000; c++) begin
         rr_  = ($urandom_range(0, 199) == 0);
         rv   = 2'($urandom_range(0, 3));
         rp0  = VL'({$urandom, $urandom});
         rp1  = VL'({$urandom, $urandom});
         fl   = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
         ak   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
         t    = $urandom_range(0, 1);
         rtid = t[0];
         rsv  = (m_issued[t] || m_killed[t]) && ($urandom_range(0, 1) == 1);
         rsm  = $urandom_range(0, 1) == 1;
         drive(rr_, rv, rp0, rp1, fl, rsv, rsm, rtid, ak);
         for (int k = 0; k < NT; k++) begin
            erdy[k] = !rr_ && m_idle(k) && !fl[k];
            eblk[k] = m_blk[k];
         end
         chk("rand req_ready", 64'(req_ready), 64'(erdy));
         chk("rand blocked",   64'(blocked),   64'(eblk));
         chk("rand bu_valid",  64'(bu_valid),  64'(m_bv));
         chk("rand bu_pc",     64'(bu_pc),     64'(m_bpc));
         chk("rand bu_tid",    64'(bu_tid),    64'(m_btid));
         model_step(rr_, rv, rp0, rp1, fl, rsv, rsm, rtid, ak);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
